// File: rtl/spike_lif_array_if.sv
// Peripheral register bus for spike_lif_array: 4-bit address, 8-bit data, one-cycle write strobe.
// The read data path is combinational from the address.
interface spike_lif_array_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/spike_lif_array.sv
// Multi-channel leaky integrate-and-fire spike encoder with a TinyQV-style register bus.
// Optional feature macro SPIKE_COUNT_EN adds per-channel 8-bit spike counters at 0xC-0xF.
module spike_lif_array #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int REFRAC_W = 4,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ui_in,
    output logic [7:0]         uo_out,
    spike_lif_array_if.slave   bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DATA_W-1:0]   r_in [NUM_CH];
    logic [DATA_W-1:0]   r_thresh;
    logic                r_en;
    logic                r_ext;
    logic [2:0]          r_leak;
    logic [REFRAC_W-1:0] r_refrac;
    logic [NUM_CH-1:0]   r_status;
    logic [NUM_CH-1:0]   r_spike;
    logic [TICK_W-1:0]   r_tick_cnt;

    logic                w_tick;
    logic [NUM_CH-1:0]   w_fire;
    logic [DATA_W-1:0]   w_v [NUM_CH];
    logic [7:0]          w_cnt [NUM_CH];
    logic                w_wr_thresh;
    logic                w_wr_ctrl;
    logic                w_wr_refrac;
    logic                w_wr_status;
    logic [1:0]          w_ch_sel;
    logic                w_ch_ok;
    logic [7:0]          w_rd;

    assign w_wr_thresh = bus.data_write && (bus.address == 4'h4);
    assign w_wr_ctrl   = bus.data_write && (bus.address == 4'h5);
    assign w_wr_refrac = bus.data_write && (bus.address == 4'h6);
    assign w_wr_status = bus.data_write && (bus.address == 4'h7);

    // The tick counter only advances while enabled; a tick is its wrap point.
    assign w_tick = r_en && (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    // Free-running tick divider, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= {TICK_W{1'b0}};
        end else if (!r_en || w_tick) begin
            r_tick_cnt <= {TICK_W{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Per-channel input value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_in[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.data_write && (bus.address == 4'(i))) begin
                    r_in[i] <= bus.data_in[DATA_W-1:0];
                end
            end
        end
    end

    // Shared configuration registers: threshold, control and refractory period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thresh <= {DATA_W{1'b0}};
            r_en     <= 1'b0;
            r_ext    <= 1'b0;
            r_leak   <= 3'd0;
            r_refrac <= {REFRAC_W{1'b0}};
        end else begin
            if (w_wr_thresh) begin
                r_thresh <= bus.data_in[DATA_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_en   <= bus.data_in[7];
                r_ext  <= bus.data_in[6];
                r_leak <= bus.data_in[2:0];
            end
            if (w_wr_refrac) begin
                r_refrac <= bus.data_in[REFRAC_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0]   r_v;
        logic [REFRAC_W-1:0] r_refr;
        logic [DATA_W-1:0]   w_x;
        logic [DATA_W-1:0]   w_leak_v;
        logic [DATA_W:0]     w_sum;
        logic [DATA_W-1:0]   w_sat;

        if (g == 0) begin : g_ext
            assign w_x = r_ext ? ui_in[DATA_W-1:0] : r_in[g];
        end else begin : g_int
            assign w_x = r_in[g];
        end

        // V - (V >> LEAK) never goes negative, so one extra bit holds the sum.
        assign w_leak_v = r_v >> r_leak;
        assign w_sum    = {1'b0, r_v} - {1'b0, w_leak_v} + {1'b0, w_x};
        assign w_sat    = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
        assign w_fire[g] = w_tick && (r_refr == {REFRAC_W{1'b0}})
                         && (r_thresh != {DATA_W{1'b0}}) && (w_sat >= r_thresh);
        assign w_v[g] = r_v;

        // Membrane potential and refractory countdown, advanced once per tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v    <= {DATA_W{1'b0}};
                r_refr <= {REFRAC_W{1'b0}};
            end else if (w_tick) begin
                if (r_refr != {REFRAC_W{1'b0}}) begin
                    r_refr <= r_refr - REFRAC_W'(1);
                    r_v    <= {DATA_W{1'b0}};
                end else if (w_fire[g]) begin
                    r_refr <= r_refrac;
                    r_v    <= {DATA_W{1'b0}};
                end else begin
                    r_v <= w_sat;
                end
            end
        end

`ifdef SPIKE_COUNT_EN
        logic [7:0] r_cnt;

        // Spike counter; a clear coinciding with a spike leaves a count of one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= 8'd0;
            end else if (bus.data_write && (bus.address[3:2] == 2'b11)) begin
                r_cnt <= {7'd0, w_fire[g]};
            end else if (w_fire[g]) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign w_cnt[g] = r_cnt;
`else
        assign w_cnt[g] = 8'h00;
`endif
    end

    // Spike pulses and sticky flags; a new spike outranks a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spike  <= {NUM_CH{1'b0}};
            r_status <= {NUM_CH{1'b0}};
        end else begin
            r_spike <= w_fire;
            if (w_wr_status) begin
                r_status <= (r_status & ~bus.data_in[NUM_CH-1:0]) | w_fire;
            end else begin
                r_status <= r_status | w_fire;
            end
        end
    end

    assign uo_out   = 8'(r_spike);
    assign w_ch_sel = bus.address[1:0];
    assign w_ch_ok  = (32'(w_ch_sel) < NUM_CH);

    // Read data multiplexer; unimplemented channels and bits read as zero.
    always_comb begin
        w_rd = 8'h00;
        case (bus.address[3:2])
            2'b00: w_rd = w_ch_ok ? 8'(r_in[w_ch_sel]) : 8'h00;
            2'b01: begin
                case (w_ch_sel)
                    2'd0:    w_rd = 8'(r_thresh);
                    2'd1:    w_rd = {r_en, r_ext, 3'b000, r_leak};
                    2'd2:    w_rd = 8'(r_refrac);
                    2'd3:    w_rd = 8'(r_status);
                    default: w_rd = 8'h00;
                endcase
            end
            2'b10:   w_rd = w_ch_ok ? 8'(w_v[w_ch_sel]) : 8'h00;
            2'b11:   w_rd = w_ch_ok ? w_cnt[w_ch_sel] : 8'h00;
            default: w_rd = 8'h00;
        endcase
    end

    assign bus.data_out = w_rd;

endmodule

// File: tb/tb_spike_lif_array.sv
// Self-checking bench for spike_lif_array: directed scenarios plus randomized register traffic,
// all compared against a tick-level arithmetic reference model.
module tb_spike_lif_array;

    localparam int NCH = 4;
    localparam int TD  = 1;

    logic       clk;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    spike_lif_array_if bus ();

    spike_lif_array #(
        .NUM_CH   (NCH),
        .DATA_W   (8),
        .REFRAC_W (4),
        .TICK_DIV (TD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // reference model state
    int m_in [NCH];
    int m_v [NCH];
    int m_refr [NCH];
    int m_cnt [NCH];
    int m_thresh, m_en, m_ext, m_leak, m_refrac, m_status, m_uo, m_tc;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_in[c] = 0; m_v[c] = 0; m_refr[c] = 0; m_cnt[c] = 0;
        end
        m_thresh = 0; m_en = 0; m_ext = 0; m_leak = 0; m_refrac = 0;
        m_status = 0; m_uo = 0; m_tc = 0;
    endfunction

    // One clock edge: tick uses pre-edge register values, then the bus write lands.
    function automatic void model_edge(input bit wr, input logic [3:0] a, input logic [7:0] d);
        int spk;
        int s;
        int x;
        int ai;
        bit tick;
        bit clr;
        spk = 0; tick = 1'b0; clr = 1'b0; ai = int'(a);
        if (m_en != 0) begin
            tick = (m_tc == TD - 1);
            m_tc = tick ? 0 : m_tc + 1;
        end else begin
            m_tc = 0;
        end
        if (tick) begin
            for (int c = 0; c < NCH; c++) begin
                x = (c == 0 && m_ext != 0) ? int'(ui_in) : m_in[c];
                if (m_refr[c] > 0) begin
                    m_refr[c] = m_refr[c] - 1;
                    m_v[c] = 0;
                end else begin
                    s = m_v[c] - (m_v[c] >> m_leak) + x;
                    if (s > 255) s = 255;
                    if (m_thresh != 0 && s >= m_thresh) begin
                        spk = spk | (1 << c);
                        m_v[c] = 0;
                        m_refr[c] = m_refrac;
                    end else begin
                        m_v[c] = s;
                    end
                end
            end
        end
        if (wr) begin
            case (ai)
                0, 1, 2, 3: m_in[ai] = int'(d);
                4: m_thresh = int'(d);
                5: begin m_en = int'(d[7]); m_ext = int'(d[6]); m_leak = int'(d[2:0]); end
                6: m_refrac = int'(d) % 16;
                7: m_status = m_status & ~int'(d) & 15;
                12, 13, 14, 15: clr = 1'b1;
                default: ;
            endcase
        end
        m_status = m_status | spk;
        for (int c = 0; c < NCH; c++) begin
            if (clr) m_cnt[c] = (spk >> c) & 1;
            else     m_cnt[c] = (m_cnt[c] + ((spk >> c) & 1)) % 256;
        end
        m_uo = spk;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai < 4) return 8'(m_in[ai]);
        if (ai == 4) return 8'(m_thresh);
        if (ai == 5) return 8'((m_en << 7) | (m_ext << 6) | m_leak);
        if (ai == 6) return 8'(m_refrac);
        if (ai == 7) return 8'(m_status);
        if (ai < 12) return 8'(m_v[ai - 8]);
`ifdef SPIKE_COUNT_EN
        return 8'(m_cnt[ai - 12]);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step(input bit wr, input logic [3:0] a, input logic [7:0] d);
        bus.address = a; bus.data_write = wr; bus.data_in = d;
        @(posedge clk);
        model_edge(wr, a, d);
        #1;
        bus.data_write = 1'b0;
        check_val("uo_out", uo_out, 8'(m_uo));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 8'h00);
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        bus.address = a;
        #1;
        check_val(tag, bus.data_out, m_read(a));
    endtask

    task automatic rdc(input logic [3:0] a, input string tag, input logic [7:0] exp);
        bus.address = a;
        #1;
        check_val(tag, bus.data_out, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_uo", uo_out, 8'h00);
        for (int k = 0; k < 16; k++) rdc(4'(k), "rst_rd", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; ui_in = 8'h00;
        bus.address = 4'h0; bus.data_write = 1'b0; bus.data_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset leaves EN=0: V holds at zero even with input present
        step(1'b1, 4'h0, 8'd50);
        idle(3);
        rdc(4'h8, "en0_v0", 8'h00);

        // Threshold 100, full leak: 99 stays silent, 100 fires every tick
        do_reset();
        step(1'b1, 4'h4, 8'd100);
        step(1'b1, 4'h6, 8'd0);
        step(1'b1, 4'h0, 8'd99);
        step(1'b1, 4'h5, 8'h80);
        idle(4);
        rdc(4'h7, "t2_nospike", 8'h00);
        step(1'b1, 4'h0, 8'd100);
        idle(2);
        check_val("t2_pulse", uo_out, 8'h01);
        rdc(4'h7, "t2_status", 8'h01);

        // W1C racing a spike keeps the flag; W1C without a spike clears it
        step(1'b1, 4'h7, 8'h01);
        rdc(4'h7, "w1c_race", 8'h01);
        step(1'b1, 4'h0, 8'd0);
        idle(1);
        step(1'b1, 4'h7, 8'h01);
        rdc(4'h7, "w1c_clear", 8'h00);

        // LEAK=1 convergence toward 120, then a lower threshold fires
        do_reset();
        step(1'b1, 4'h4, 8'd200);
        step(1'b1, 4'h1, 8'd60);
        step(1'b1, 4'h5, 8'h81);
        idle(1); rdc(4'h9, "v1_60", 8'd60);
        idle(1); rdc(4'h9, "v1_90", 8'd90);
        idle(1); rdc(4'h9, "v1_105", 8'd105);
        idle(8); rdc(4'h9, "v1_conv", 8'd120);
        step(1'b1, 4'h4, 8'd110);
        idle(1);
        check_val("v1_spike", uo_out, 8'h02);
        rdc(4'h9, "v1_zero", 8'h00);

        // Refractory period of 3 ticks between ch2 pulses
        do_reset();
        step(1'b1, 4'h4, 8'd10);
        step(1'b1, 4'h6, 8'd3);
        step(1'b1, 4'h2, 8'd255);
        step(1'b1, 4'h5, 8'h80);
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 12; k++) begin
                idle(1);
                if (uo_out[2]) pulses++;
                rd(4'hA, "v2_refr");
            end
            check_val("refr_pulses", 8'(pulses), 8'd3);
        end

        // External input drives ch0 at 0xFF every tick; counter wraps at 256
        do_reset();
        ui_in = 8'hFF;
        step(1'b1, 4'h4, 8'hFF);
        step(1'b1, 4'h5, 8'hC0);
        idle(255);
`ifdef SPIKE_COUNT_EN
        rdc(4'hC, "cnt_255", 8'd255);
        idle(1);
        rdc(4'hC, "cnt_wrap", 8'd0);
        step(1'b1, 4'hD, 8'h00);
        rdc(4'hC, "cnt_clr_spike", 8'd1);
`else
        idle(1);
        rdc(4'hC, "cnt_absent", 8'h00);
`endif
        step(1'b1, 4'h4, 8'h00);
        idle(3);
        check_val("thresh0_quiet", uo_out, 8'h00);
        rdc(4'h0, "ext_in0", 8'h00);

        // Randomized register traffic with a mid-run reset
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [3:0] a;
            logic [7:0] d;
            ui_in = 8'($urandom);
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            if (a == 4'h5) d[7] = ($urandom_range(0, 4) != 0);
            if (a == 4'h4 && $urandom_range(0, 1) == 1) d = 8'($urandom_range(1, 40));
            if (cyc == 750) do_reset();
            step($urandom_range(0, 3) == 0, a, d);
            rd(4'($urandom_range(0, 15)), "rand_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
